toag_stream_reducer: RTL and testbench
======================================

// Module: toag_stream_reducer
// PURPOSE
//  Parametrised successor to the 1-bit toggle/AND resumption device.
//  - Accepts a stream of CH-lane words over a valid/ready handshake.
//  - Folds DEPTH accepted beats per window with a runtime-selected boolean operator (AND/OR/XOR/PASS).
//  - Emits one reduced word per window, held until the consumer accepts it.
//  - Sits between a ReWire-generated producer and a downstream sink.
// PARAMETERS
//  W      1  bits per lane
//  CH     1  number of independent lanes; data buses are CH*W wide
//  DEPTH  4  beats per window, >=1; counter width CW = $clog2(DEPTH+1)
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     reset, asynchronous, active-low (0 = reset)
//  mode       in   2     00 AND, 01 OR, 10 XOR, 11 PASS (keep latest beat); sampled at window start
//  in_valid   in   1     producer has a beat
//  in_ready   out  1     block accepts a beat this cycle
//  in_data    in   CH*W  lane c occupies bits [c*W +: W]
//  flush      in   1     close the current partial window early
//  out_valid  out  1     reduced word available
//  out_ready  in   1     sink accepts the word
//  out_data   out  CH*W  reduced word
//  out_cnt    out  CW    number of beats folded into out_data
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//  - state=IDLE; acc, cnt and mode_q cleared.
//  - Outputs: out_valid=0, out_data=0, out_cnt=0, in_ready=1.
//  Accept / transfer rules:
//  - A beat is accepted when in_valid & in_ready on a rising edge.
//  - An output word is transferred when out_valid & out_ready on a rising edge.
//  - in_ready = (state != EMIT); it is combinational from state only.
//  - out_valid, out_data and out_cnt are registered.
//  IDLE:
//  - On accept: acc<=in_data, cnt<=1, mode_q<=mode.
//  - If DEPTH==1, go to EMIT; otherwise go to ACC.
//  - flush in IDLE is ignored (no empty windows are emitted).
//  ACC:
//  - On accept: acc<=op(mode_q, acc, in_data), applied per lane, bitwise; cnt<=cnt+1.
//  - Go to EMIT when the new cnt==DEPTH, or when flush=1.
//  - flush together with an accept: the beat is folded first, then the window closes.
//  - flush with no accept: the partial window closes with the current cnt.
//  EMIT:
//  - out_valid=1, out_data=acc, out_cnt=cnt; held stable while out_ready=0.
//  - On transfer: go to IDLE and clear cnt.
//  - No input is taken in the transfer cycle (bubble).
//  - Minimum window period is DEPTH+1 cycles.
//  - mode changes mid-window are ignored until the next window starts.
//  Arithmetic:
//  - PASS: acc<=in_data.
//  - cnt never exceeds DEPTH, so no wrap-around is possible.
//  - Lanes are fully independent; no carries between lanes.
//  Reset mid-window or mid-EMIT: the partial result is discarded and no output is produced.
// STRUCTURE
//  Package toag_pkg:
//  - typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_PASS} toag_op_t
//  - typedef enum logic [1:0] {S_IDLE, S_ACC, S_EMIT} toag_state_t
//  - function toag_fold(op, a, b) for a W-bit lane
//  Sub-module toag_lane (combinational, one W-bit lane fold):
//  - Instantiated CH times via generate.
//  - The top level holds the FSM, counter and registers.
// TESTING
//  1. W=1,CH=1,DEPTH=4, AND, beats 1,1,1,1, out_ready=1
//     -> out_valid exactly 1 cycle after the 4th accept; out_data=1, out_cnt=4.
//  2. Same configuration, beats 1,0,1,1
//     -> out_data=0, out_cnt=4; in_ready=0 during EMIT.
//  3. CH=2,W=4,DEPTH=3, XOR, beats 0x12,0x34,0x56
//     -> out_data=0x70 (0x1^0x3^0x5=0x7, 0x2^0x4^0x6=0x0), out_cnt=3.
//  4. DEPTH=4, OR, two beats 0x0 then 0x1 with flush on the 2nd beat
//     -> out_data=0x1, out_cnt=2; flush asserted in IDLE afterwards produces no output.
//  5. Backpressure: out_ready=0 for 5 cycles during EMIT
//     -> out_data and out_cnt stable; in_ready=0 throughout; out_valid drops the cycle after out_ready=1.
//  6. rst driven low asynchronously mid-ACC (cnt=2)
//     -> out_valid=0 and in_ready=1 immediately; a fresh window after release yields out_cnt=DEPTH.

Source files
------------

// File: rtl/toag_pkg.sv
// Shared types and the per-lane fold operator for the toag stream reducer.
package toag_pkg;

  // Widest lane the fold helper handles; lanes narrower than this are
  // zero-extended going in and truncated coming out.
  localparam int TOAG_LANE_MAX_W = 64;

  typedef logic [TOAG_LANE_MAX_W-1:0] toag_lane_t;

  // Encoding matches the 2-bit mode input directly.
  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_PASS = 2'b11
  } toag_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACC  = 2'b01,
    S_EMIT = 2'b10
  } toag_state_t;

  // Fold a new beat b into the running value a. All operators are bitwise,
  // so upper zero-extension bits never affect the low lane bits.
  function automatic toag_lane_t toag_fold(toag_op_t op, toag_lane_t a, toag_lane_t b);
    toag_lane_t r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = b;  // PASS keeps the latest beat
    endcase
    return r;
  endfunction

endpackage

// File: rtl/toag_lane.sv
// One W-bit lane of the reducer datapath: purely combinational fold of the
// accumulated lane value with the incoming lane value. W must not exceed
// TOAG_LANE_MAX_W.
module toag_lane
  import toag_pkg::*;
#(
  parameter int W = 1
) (
  input  toag_op_t       op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   y
);

  assign y = W'(toag_fold(op, toag_lane_t'(a), toag_lane_t'(b)));

endmodule

// File: rtl/toag_stream_reducer.sv
// Stream reducer: folds DEPTH accepted beats (or fewer, on flush) of a CH-lane
// stream with a per-window boolean operator and presents one registered
// result word per window over a valid/ready handshake.
module toag_stream_reducer
  import toag_pkg::*;
#(
  parameter  int W     = 1,
  parameter  int CH    = 1,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*W-1:0] in_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*W-1:0] out_data,
  output logic [CW-1:0]   out_cnt
);

  localparam int DW = CH * W;

  toag_state_t   state_q, state_d;
  toag_op_t      mode_q, mode_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;

  logic [DW-1:0] fold_res;
  logic          accept;
  logic          xfer;
  logic          go_emit;

  // Input is blocked only while a result is waiting, which also gives the
  // one-cycle bubble on the transfer cycle.
  assign in_ready = (state_q != S_EMIT);
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid_q & out_ready;

  // Lanes are independent: one fold slice per lane, no cross-lane terms.
  for (genvar c = 0; c < CH; c++) begin : g_lane
    toag_lane #(.W(W)) u_lane (
      .op (mode_q),
      .a  (acc_q[c*W +: W]),
      .b  (in_data[c*W +: W]),
      .y  (fold_res[c*W +: W])
    );
  end

  // Next-state logic for the window FSM, accumulator, counter and outputs.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    go_emit     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A window opens only with a real beat; flush here has nothing to close.
        if (accept) begin
          acc_d  = in_data;
          cnt_d  = CW'(1);
          mode_d = toag_op_t'(mode);
          if (DEPTH == 1) begin
            go_emit = 1'b1;
          end else begin
            state_d = S_ACC;
          end
        end
      end

      S_ACC: begin
        // A beat arriving with flush is folded before the window closes.
        if (accept) begin
          acc_d = fold_res;
          cnt_d = cnt_q + CW'(1);
        end
        if ((cnt_d == CW'(DEPTH)) || flush) begin
          go_emit = 1'b1;
        end
      end

      S_EMIT: begin
        if (xfer) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Results are captured into the output registers on the closing edge so
    // they are stable for the whole EMIT period.
    if (go_emit) begin
      state_d     = S_EMIT;
      out_valid_d = 1'b1;
      out_data_d  = acc_d;
      out_cnt_d   = cnt_d;
    end
  end

  // State and output registers; reset discards any partial window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mode_q      <= OP_AND;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q     <= state_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_toag_stream_reducer.sv
// Directed bench for toag_stream_reducer using three configurations:
//   A: W=1 CH=1 DEPTH=4   B: W=4 CH=2 DEPTH=3   C: W=2 CH=1 DEPTH=1
module tb_toag_stream_reducer;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // Configuration A
  logic [1:0] a_mode;
  logic       a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [0:0] a_in_data, a_out_data;
  logic [2:0] a_out_cnt;

  // Configuration B
  logic [1:0] b_mode;
  logic       b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_out_cnt;

  // Configuration C
  logic [1:0] c_mode;
  logic       c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready;
  logic [1:0] c_in_data, c_out_data;
  logic [0:0] c_out_cnt;

  toag_stream_reducer #(.W(1), .CH(1), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .mode(a_mode), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_cnt(a_out_cnt)
  );

  toag_stream_reducer #(.W(4), .CH(2), .DEPTH(3)) dut_b (
    .clk(clk), .rst(rst), .mode(b_mode), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_cnt(b_out_cnt)
  );

  toag_stream_reducer #(.W(2), .CH(1), .DEPTH(1)) dut_c (
    .clk(clk), .rst(rst), .mode(c_mode), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .flush(c_flush), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_cnt(c_out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input logic d, input logic f);
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_flush    = f;
    tick();
    a_in_valid = 1'b0;
    a_flush    = 1'b0;
  endtask

  task automatic b_beat(input logic [7:0] d);
    b_in_valid = 1'b1;
    b_in_data  = d;
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic c_beat(input logic [1:0] d);
    c_in_valid = 1'b1;
    c_in_data  = d;
    tick();
    c_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got %b want 0", a_out_valid); end
    checks++; if (a_out_data !== 1'b0) begin errors++; $display("FAIL rst_a_data got %h want 0", a_out_data); end
    checks++; if (a_out_cnt !== 3'd0) begin errors++; $display("FAIL rst_a_cnt got %0d want 0", a_out_cnt); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_a_in_ready got %b want 1", a_in_ready); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid got %b want 0", b_out_valid); end
    checks++; if (b_out_data !== 8'h00) begin errors++; $display("FAIL rst_b_data got %h want 00", b_out_data); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rst_b_in_ready got %b want 1", b_in_ready); end
    checks++; if (c_out_cnt !== 1'd0) begin errors++; $display("FAIL rst_c_cnt got %0d want 0", c_out_cnt); end
  endtask

  // AND of four ones; result must appear right after the 4th accept.
  task automatic test_and_ones();
    a_mode = 2'b00; a_out_ready = 1'b1;
    a_beat(1'b1, 1'b0); a_beat(1'b1, 1'b0); a_beat(1'b1, 1'b0);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL and1_early_valid got %b want 0", a_out_valid); end
    a_beat(1'b1, 1'b0);
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL and1_valid got %b want 1", a_out_valid); end
    checks++; if (a_out_data !== 1'b1) begin errors++; $display("FAIL and1_data got %h want 1", a_out_data); end
    checks++; if (a_out_cnt !== 3'd4) begin errors++; $display("FAIL and1_cnt got %0d want 4", a_out_cnt); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL and1_drop got %b want 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL and1_ready_back got %b want 1", a_in_ready); end
  endtask

  // AND with one zero beat; input must be blocked while the result is held.
  task automatic test_and_mixed();
    a_mode = 2'b00; a_out_ready = 1'b1;
    a_beat(1'b1, 1'b0); a_beat(1'b0, 1'b0); a_beat(1'b1, 1'b0); a_beat(1'b1, 1'b0);
    checks++; if (a_out_data !== 1'b0) begin errors++; $display("FAIL and2_data got %h want 0", a_out_data); end
    checks++; if (a_out_cnt !== 3'd4) begin errors++; $display("FAIL and2_cnt got %0d want 4", a_out_cnt); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL and2_in_ready got %b want 0", a_in_ready); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL and2_drop got %b want 0", a_out_valid); end
  endtask

  // Two 4-bit lanes XORed independently; a mid-window mode change is ignored.
  task automatic test_xor_lanes();
    b_mode = 2'b10; b_out_ready = 1'b1;
    b_beat(8'h12);
    b_mode = 2'b00;
    b_beat(8'h34);
    b_beat(8'h56);
    checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL xor_valid got %b want 1", b_out_valid); end
    checks++; if (b_out_data !== 8'h70) begin errors++; $display("FAIL xor_data got %h want 70", b_out_data); end
    checks++; if (b_out_cnt !== 2'd3) begin errors++; $display("FAIL xor_cnt got %0d want 3", b_out_cnt); end
    tick();
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL xor_drop got %b want 0", b_out_valid); end
  endtask

  // Early close with flush: with a beat, in IDLE (ignored), and on its own.
  task automatic test_flush();
    a_mode = 2'b01; a_out_ready = 1'b1;
    a_beat(1'b0, 1'b0); a_beat(1'b1, 1'b1);
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL fl_valid got %b want 1", a_out_valid); end
    checks++; if (a_out_data !== 1'b1) begin errors++; $display("FAIL fl_data got %h want 1", a_out_data); end
    checks++; if (a_out_cnt !== 3'd2) begin errors++; $display("FAIL fl_cnt got %0d want 2", a_out_cnt); end
    tick();
    a_flush = 1'b1;
    tick(); tick(); tick();
    a_flush = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL fl_idle_valid got %b want 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL fl_idle_ready got %b want 1", a_in_ready); end
    a_beat(1'b1, 1'b0);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL fl_alone_valid got %b want 1", a_out_valid); end
    checks++; if (a_out_cnt !== 3'd1) begin errors++; $display("FAIL fl_alone_cnt got %0d want 1", a_out_cnt); end
    tick();
  endtask

  // Held result under backpressure, then a bubble on the transfer cycle.
  task automatic test_backpressure();
    a_mode = 2'b00; a_out_ready = 1'b0;
    a_beat(1'b1, 1'b0); a_beat(1'b1, 1'b0); a_beat(1'b1, 1'b0); a_beat(1'b1, 1'b0);
    a_in_valid = 1'b1; a_in_data = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", i, a_out_valid); end
      checks++; if (a_out_data !== 1'b1 || a_out_cnt !== 3'd4) begin errors++; $display("FAIL bp_hold[%0d] got %h/%0d want 1/4", i, a_out_data, a_out_cnt); end
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0", i, a_in_ready); end
    end
    a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop got %b want 0", a_out_valid); end
    // A beat taken during the transfer cycle would show up as cnt 4 / data 0.
    a_beat(1'b1, 1'b0); a_beat(1'b1, 1'b0); a_beat(1'b1, 1'b1);
    checks++; if (a_out_cnt !== 3'd3) begin errors++; $display("FAIL bp_bubble_cnt got %0d want 3", a_out_cnt); end
    checks++; if (a_out_data !== 1'b1) begin errors++; $display("FAIL bp_bubble_data got %h want 1", a_out_data); end
    tick();
  endtask

  // Asynchronous reset mid-ACC (A) and mid-EMIT (B), then a clean window.
  task automatic test_reset_mid();
    a_mode = 2'b00; a_out_ready = 1'b1;
    b_mode = 2'b01; b_out_ready = 1'b0;
    b_beat(8'h01); b_beat(8'h02); b_beat(8'h04);
    a_beat(1'b1, 1'b0); a_beat(1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rm_a_valid got %b want 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rm_a_ready got %b want 1", a_in_ready); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rm_b_valid got %b want 0", b_out_valid); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rm_b_ready got %b want 1", b_in_ready); end
    @(negedge clk);
    rst = 1'b1;
    b_out_ready = 1'b1;
    a_beat(1'b1, 1'b0); a_beat(1'b1, 1'b0); a_beat(1'b1, 1'b0);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rm_early got %b want 0", a_out_valid); end
    a_beat(1'b1, 1'b0);
    checks++; if (a_out_cnt !== 3'd4) begin errors++; $display("FAIL rm_cnt got %0d want 4", a_out_cnt); end
    checks++; if (a_out_data !== 1'b1) begin errors++; $display("FAIL rm_data got %h want 1", a_out_data); end
    tick();
  endtask

  // DEPTH=1 closes each window on its only beat; PASS keeps that beat.
  task automatic test_depth_one();
    c_mode = 2'b11; c_out_ready = 1'b1;
    c_beat(2'b10);
    checks++; if (c_out_valid !== 1'b1) begin errors++; $display("FAIL d1_valid got %b want 1", c_out_valid); end
    checks++; if (c_out_data !== 2'b10) begin errors++; $display("FAIL d1_data got %h want 2", c_out_data); end
    checks++; if (c_out_cnt !== 1'd1) begin errors++; $display("FAIL d1_cnt got %0d want 1", c_out_cnt); end
    checks++; if (c_in_ready !== 1'b0) begin errors++; $display("FAIL d1_ready got %b want 0", c_in_ready); end
    tick();
    c_beat(2'b01);
    checks++; if (c_out_data !== 2'b01) begin errors++; $display("FAIL d1_data2 got %h want 1", c_out_data); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    a_mode = '0; a_in_valid = 1'b0; a_in_data = '0; a_flush = 1'b0; a_out_ready = 1'b1;
    b_mode = '0; b_in_valid = 1'b0; b_in_data = '0; b_flush = 1'b0; b_out_ready = 1'b1;
    c_mode = '0; c_in_valid = 1'b0; c_in_data = '0; c_flush = 1'b0; c_out_ready = 1'b1;
    #2 rst = 1'b0;
    #20;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_and_ones();
    test_and_mixed();
    test_xor_lanes();
    test_flush();
    test_backpressure();
    test_reset_mid();
    test_depth_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
